// File: rtl/sparc_ifu_milcam_pkg.sv
// Shared defaults and priority helpers for the IFU miss-address CAM.
// Helpers work on a 16-bit vector; callers zero-extend and truncate to NENT/IW.
package sparc_ifu_milcam_pkg;

  localparam int MIL_AW   = 35;
  localparam int MIL_NENT = 4;

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [15:0] lowest_set(input logic [15:0] v);
    return v & (~v + 16'd1);
  endfunction

  // Binary index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [3:0] oh_encode(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sparc_ifu_milcam_if.sv
// Allocation, free, lookup and status signals of the MIL miss-address CAM.
// master drives requests; slave is the CAM.
interface sparc_ifu_milcam_if
  import sparc_ifu_milcam_pkg::*;
#(
  parameter int AW   = MIL_AW,
  parameter int NENT = MIL_NENT,
  parameter int IW   = $clog2(NENT)
) ();

  logic            alloc_vld;
  logic [AW-1:0]   alloc_addr;
  logic            alloc_ok;
  logic [IW-1:0]   alloc_idx;
  logic            free_vld;
  logic [IW-1:0]   free_idx;
  logic            lkup_vld;
  logic [AW-1:0]   lkup_addr;
  logic            hit_q;
  logic [NENT-1:0] hit_vec_q;
  logic [IW-1:0]   hit_idx_q;
  logic            rej_q;
  logic [NENT-1:0] vld_vec;
  logic            full;
  logic            empty;

  modport master (
    output alloc_vld, alloc_addr, free_vld, free_idx, lkup_vld, lkup_addr,
    input  alloc_ok, alloc_idx, hit_q, hit_vec_q, hit_idx_q, rej_q, vld_vec, full, empty
  );

  modport slave (
    input  alloc_vld, alloc_addr, free_vld, free_idx, lkup_vld, lkup_addr,
    output alloc_ok, alloc_idx, hit_q, hit_vec_q, hit_idx_q, rej_q, vld_vec, full, empty
  );

endinterface

// File: rtl/sparc_ifu_milcam_ent.sv
// One CAM entry: miss-address register with valid-gated lookup and duplicate compares.
// Compares are combinational; the address register is written on the edge after wr_en.
module sparc_ifu_milcam_ent
  import sparc_ifu_milcam_pkg::*;
#(
  parameter int AW = MIL_AW
) (
  input  logic          rclk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          vld,
  input  logic [AW-1:0] lkup_addr,
  input  logic [AW-1:0] chk_addr,
  output logic          lkup_hit,
  output logic          chk_hit
);

  logic [AW-1:0] addr_q;

  // Contents are only meaningful while vld is set, so no reset is needed.
  always_ff @(posedge rclk) begin
    if (wr_en) addr_q <= wr_addr;
  end

  assign lkup_hit = vld & (addr_q == lkup_addr);
  assign chk_hit  = vld & (addr_q == chk_addr);

endmodule

// File: rtl/sparc_ifu_milcam.sv
// MIL miss-address CAM: lowest-free allocation, free by index, registered 1-cycle lookup.
// Never stalls; a full or duplicate allocation is dropped and flagged on rej_q.
module sparc_ifu_milcam
  import sparc_ifu_milcam_pkg::*;
#(
  parameter int AW   = MIL_AW,
  parameter int NENT = MIL_NENT,
  parameter int IW   = $clog2(NENT)
) (
  input logic               rclk,
  input logic               arst_l,
  sparc_ifu_milcam_if.slave mif
);

  logic [NENT-1:0] vld_q;
  logic [NENT-1:0] fv;
  logic [NENT-1:0] alloc_oh;
  logic [NENT-1:0] free_oh;
  logic [NENT-1:0] lkup_m;
  logic [NENT-1:0] dup_m;
  logic [NENT-1:0] m;
  logic [NENT-1:0] nxt_hit_vec;
  logic            dup;
  logic            alloc_ok;
  logic            byp;
  logic            hit_q;
  logic [NENT-1:0] hit_vec_q;
  logic [IW-1:0]   hit_idx_q;
  logic            rej_q;

  // Free vector predates this cycle's free, so a freed slot is reusable only next cycle.
  assign fv       = ~vld_q;
  assign alloc_oh = NENT'(lowest_set(16'(fv)));
  assign dup      = |dup_m;
  assign alloc_ok = mif.alloc_vld & (|fv) & ~dup;

  for (genvar g = 0; g < NENT; g++) begin : g_ent
    sparc_ifu_milcam_ent #(.AW(AW)) u_ent (
      .rclk      (rclk),
      .wr_en     (alloc_ok & alloc_oh[g]),
      .wr_addr   (mif.alloc_addr),
      .vld       (vld_q[g]),
      .lkup_addr (mif.lkup_addr),
      .chk_addr  (mif.alloc_addr),
      .lkup_hit  (lkup_m[g]),
      .chk_hit   (dup_m[g])
    );
    assign free_oh[g] = mif.free_vld & (mif.free_idx == IW'(g));
  end

  // A same-cycle allocation of the looked-up address hits in its new slot.
  assign byp         = alloc_ok & (mif.alloc_addr == mif.lkup_addr);
  assign m           = lkup_m | (byp ? alloc_oh : '0);
  assign nxt_hit_vec = mif.lkup_vld ? m : '0;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      vld_q     <= '0;
      hit_q     <= 1'b0;
      hit_vec_q <= '0;
      hit_idx_q <= '0;
      rej_q     <= 1'b0;
    end else begin
      vld_q     <= (vld_q & ~free_oh) | (alloc_ok ? alloc_oh : '0);
      hit_q     <= |nxt_hit_vec;
      hit_vec_q <= nxt_hit_vec;
      hit_idx_q <= IW'(oh_encode(16'(nxt_hit_vec)));
      rej_q     <= mif.alloc_vld & ~alloc_ok;
    end
  end

  assign mif.alloc_ok  = alloc_ok;
  assign mif.alloc_idx = IW'(oh_encode(16'(alloc_oh)));
  assign mif.hit_q     = hit_q;
  assign mif.hit_vec_q = hit_vec_q;
  assign mif.hit_idx_q = hit_idx_q;
  assign mif.rej_q     = rej_q;
  assign mif.vld_vec   = vld_q;
  assign mif.full      = &vld_q;
  assign mif.empty     = ~|vld_q;

endmodule

// File: tb/tb_sparc_ifu_milcam.sv
// Bench for sparc_ifu_milcam: directed scenarios plus random traffic against an entry-array model.
module tb_sparc_ifu_milcam;

  localparam int AW   = 35;
  localparam int NENT = 4;
  localparam int IW   = 2;

  logic rclk   = 1'b0;
  logic arst_l = 1'b0;

  sparc_ifu_milcam_if #(.AW(AW), .NENT(NENT), .IW(IW)) mif ();

  sparc_ifu_milcam #(.AW(AW), .NENT(NENT), .IW(IW)) dut (
    .rclk   (rclk),
    .arst_l (arst_l),
    .mif    (mif)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: which slots hold a miss and what address each holds.
  bit            mv [NENT];
  logic [AW-1:0] ma [NENT];

  // Expectations for the cycle just applied, and the comb outputs observed in it.
  bit              e_ok;
  int              e_idx;
  logic [NENT-1:0] e_vec;
  bit              e_hit;
  int              e_hidx;
  bit              e_rej;
  logic            o_ok;
  logic [IW-1:0]   o_idx;

  function automatic logic [NENT-1:0] model_vec();
    logic [NENT-1:0] v;
    for (int i = 0; i < NENT; i++) v[i] = mv[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NENT; i++) mv[i] = 1'b0;
  endtask

  // Drive one cycle of requests, predict the results, and step past the clock edge.
  task automatic apply(input bit av, input logic [AW-1:0] aa, input bit fvl, input int fi,
                       input bit lv, input logic [AW-1:0] la);
    bit dup;
    int fidx;
    mif.alloc_vld  = av;
    mif.alloc_addr = aa;
    mif.free_vld   = fvl;
    mif.free_idx   = IW'(fi);
    mif.lkup_vld   = lv;
    mif.lkup_addr  = la;
    #1;
    o_ok  = mif.alloc_ok;
    o_idx = mif.alloc_idx;
    dup  = 1'b0;
    fidx = -1;
    for (int i = 0; i < NENT; i++) begin
      if (mv[i] && ma[i] == aa) dup = 1'b1;
      if (!mv[i] && fidx < 0) fidx = i;
    end
    e_ok  = av && (fidx >= 0) && !dup;
    e_idx = (fidx < 0) ? 0 : fidx;
    e_vec = '0;
    if (lv) begin
      for (int i = 0; i < NENT; i++) if (mv[i] && ma[i] == la) e_vec[i] = 1'b1;
      if (e_ok && aa == la) e_vec[e_idx] = 1'b1;
    end
    e_hit  = |e_vec;
    e_hidx = 0;
    for (int i = NENT - 1; i >= 0; i--) if (e_vec[i]) e_hidx = i;
    e_rej = av && !e_ok;
    if (fvl) mv[fi] = 1'b0;
    if (e_ok) begin
      mv[e_idx] = 1'b1;
      ma[e_idx] = aa;
    end
    @(posedge rclk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, '0, 1'b0, 0, 1'b0, '0);
  endtask

  task automatic test_reset();
    mif.alloc_vld = 1'b0; mif.alloc_addr = '0; mif.free_vld = 1'b0;
    mif.free_idx = '0;    mif.lkup_vld = 1'b0; mif.lkup_addr = '0;
    arst_l = 1'b0;
    model_clear();
    #12;
    n_cmp++; if (mif.vld_vec !== 4'b0000) begin n_err++; $display("FAIL reset_vld_vec got=%b exp=0000", mif.vld_vec); end
    n_cmp++; if (mif.hit_q !== 1'b0) begin n_err++; $display("FAIL reset_hit_q got=%b exp=0", mif.hit_q); end
    n_cmp++; if (mif.hit_vec_q !== 4'b0000) begin n_err++; $display("FAIL reset_hit_vec got=%b exp=0000", mif.hit_vec_q); end
    n_cmp++; if (mif.hit_idx_q !== 2'd0) begin n_err++; $display("FAIL reset_hit_idx got=%0d exp=0", mif.hit_idx_q); end
    n_cmp++; if (mif.rej_q !== 1'b0) begin n_err++; $display("FAIL reset_rej_q got=%b exp=0", mif.rej_q); end
    n_cmp++; if (mif.empty !== 1'b1 || mif.full !== 1'b0) begin n_err++; $display("FAIL reset_empty_full got=%b%b exp=10", mif.empty, mif.full); end
    @(negedge rclk);
    arst_l = 1'b1;
    @(posedge rclk);
    #1;
  endtask

  task automatic test_alloc_lookup();
    apply(1'b1, 35'h1_0000_0040, 1'b0, 0, 1'b0, '0);
    n_cmp++; if (o_ok !== 1'b1 || o_idx !== 2'd0) begin n_err++; $display("FAIL first_alloc ok/idx got=%b/%0d exp=1/0", o_ok, o_idx); end
    n_cmp++; if (mif.vld_vec !== 4'b0001 || mif.empty !== 1'b0) begin n_err++; $display("FAIL first_alloc vld/empty got=%b/%b exp=0001/0", mif.vld_vec, mif.empty); end
    apply(1'b0, '0, 1'b0, 0, 1'b1, 35'h1_0000_0040);
    n_cmp++; if (mif.hit_q !== 1'b1 || mif.hit_vec_q !== 4'b0001 || mif.hit_idx_q !== 2'd0) begin n_err++; $display("FAIL lookup_hit got=%b/%b/%0d exp=1/0001/0", mif.hit_q, mif.hit_vec_q, mif.hit_idx_q); end
    apply(1'b0, '0, 1'b0, 0, 1'b1, 35'h40);
    n_cmp++; if (mif.hit_q !== 1'b0 || mif.hit_vec_q !== 4'b0000) begin n_err++; $display("FAIL lookup_miss got=%b/%b exp=0/0000", mif.hit_q, mif.hit_vec_q); end
  endtask

  task automatic test_dup();
    apply(1'b1, 35'h500, 1'b0, 0, 1'b0, '0);
    n_cmp++; if (o_ok !== 1'b1 || o_idx !== 2'd1) begin n_err++; $display("FAIL dup_first ok/idx got=%b/%0d exp=1/1", o_ok, o_idx); end
    apply(1'b1, 35'h500, 1'b0, 0, 1'b0, '0);
    n_cmp++; if (o_ok !== 1'b0) begin n_err++; $display("FAIL dup_second ok got=%b exp=0", o_ok); end
    n_cmp++; if (mif.rej_q !== 1'b1 || mif.vld_vec !== 4'b0011) begin n_err++; $display("FAIL dup_second rej/vld got=%b/%b exp=1/0011", mif.rej_q, mif.vld_vec); end
    apply(1'b0, '0, 1'b1, 1, 1'b0, '0);
    n_cmp++; if (mif.rej_q !== 1'b0 || mif.vld_vec !== 4'b0001) begin n_err++; $display("FAIL dup_free rej/vld got=%b/%b exp=0/0001", mif.rej_q, mif.vld_vec); end
  endtask

  task automatic test_full();
    apply(1'b1, 35'h1000, 1'b0, 0, 1'b0, '0);
    apply(1'b1, 35'h2000, 1'b0, 0, 1'b0, '0);
    apply(1'b1, 35'h3000, 1'b0, 0, 1'b0, '0);
    n_cmp++; if (mif.vld_vec !== 4'b1111 || mif.full !== 1'b1) begin n_err++; $display("FAIL fill vld/full got=%b/%b exp=1111/1", mif.vld_vec, mif.full); end
    apply(1'b1, 35'h80, 1'b0, 0, 1'b0, '0);
    n_cmp++; if (o_ok !== 1'b0 || mif.rej_q !== 1'b1) begin n_err++; $display("FAIL full_alloc ok/rej got=%b/%b exp=0/1", o_ok, mif.rej_q); end
    idle();
    n_cmp++; if (mif.rej_q !== 1'b0) begin n_err++; $display("FAIL rej_one_cycle got=%b exp=0", mif.rej_q); end
    apply(1'b1, 35'h2000, 1'b0, 0, 1'b0, '0);
    n_cmp++; if (mif.rej_q !== 1'b1 || mif.vld_vec !== 4'b1111) begin n_err++; $display("FAIL realloc_valid rej/vld got=%b/%b exp=1/1111", mif.rej_q, mif.vld_vec); end
  endtask

  task automatic test_free_alloc_same();
    apply(1'b1, 35'hC0, 1'b1, 2, 1'b0, '0);
    n_cmp++; if (o_ok !== 1'b0 || mif.rej_q !== 1'b1 || mif.vld_vec !== 4'b1011) begin n_err++; $display("FAIL free_alloc_same ok/rej/vld got=%b/%b/%b exp=0/1/1011", o_ok, mif.rej_q, mif.vld_vec); end
    apply(1'b1, 35'hC0, 1'b0, 0, 1'b0, '0);
    n_cmp++; if (o_ok !== 1'b1 || o_idx !== 2'd2 || mif.vld_vec !== 4'b1111) begin n_err++; $display("FAIL reuse_slot ok/idx/vld got=%b/%0d/%b exp=1/2/1111", o_ok, o_idx, mif.vld_vec); end
  endtask

  task automatic test_bypass();
    apply(1'b0, '0, 1'b1, 1, 1'b0, '0);
    apply(1'b1, 35'h100, 1'b0, 0, 1'b1, 35'h100);
    n_cmp++; if (o_ok !== 1'b1 || o_idx !== 2'd1) begin n_err++; $display("FAIL bypass_alloc ok/idx got=%b/%0d exp=1/1", o_ok, o_idx); end
    n_cmp++; if (mif.hit_q !== 1'b1 || mif.hit_idx_q !== 2'd1 || mif.hit_vec_q !== 4'b0010) begin n_err++; $display("FAIL bypass_hit got=%b/%0d/%b exp=1/1/0010", mif.hit_q, mif.hit_idx_q, mif.hit_vec_q); end
    apply(1'b0, '0, 1'b1, 1, 1'b1, 35'h100);
    n_cmp++; if (mif.hit_q !== 1'b1 || mif.hit_idx_q !== 2'd1 || mif.vld_vec !== 4'b1101) begin n_err++; $display("FAIL free_lookup hit/idx/vld got=%b/%0d/%b exp=1/1/1101", mif.hit_q, mif.hit_idx_q, mif.vld_vec); end
  endtask

  task automatic test_back_to_back();
    apply(1'b0, '0, 1'b0, 0, 1'b1, 35'h1_0000_0040);
    n_cmp++; if (mif.hit_q !== 1'b1 || mif.hit_idx_q !== 2'd0) begin n_err++; $display("FAIL b2b_0 got=%b/%0d exp=1/0", mif.hit_q, mif.hit_idx_q); end
    apply(1'b0, '0, 1'b0, 0, 1'b1, 35'hC0);
    n_cmp++; if (mif.hit_q !== 1'b1 || mif.hit_idx_q !== 2'd2) begin n_err++; $display("FAIL b2b_2 got=%b/%0d exp=1/2", mif.hit_q, mif.hit_idx_q); end
    apply(1'b0, '0, 1'b0, 0, 1'b1, 35'h3000);
    n_cmp++; if (mif.hit_q !== 1'b1 || mif.hit_idx_q !== 2'd3 || mif.hit_vec_q !== 4'b1000) begin n_err++; $display("FAIL b2b_3 got=%b/%0d/%b exp=1/3/1000", mif.hit_q, mif.hit_idx_q, mif.hit_vec_q); end
  endtask

  task automatic test_async_reset();
    apply(1'b0, '0, 1'b0, 0, 1'b1, 35'h3000);
    n_cmp++; if (mif.hit_q !== 1'b1) begin n_err++; $display("FAIL pre_reset_hit got=%b exp=1", mif.hit_q); end
    #1;
    arst_l = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (mif.vld_vec !== 4'b0000 || mif.hit_q !== 1'b0 || mif.hit_vec_q !== 4'b0000) begin n_err++; $display("FAIL async_reset vld/hit/vec got=%b/%b/%b exp=0000/0/0000", mif.vld_vec, mif.hit_q, mif.hit_vec_q); end
    #1;
    arst_l = 1'b1;
    @(posedge rclk);
    #1;
    n_cmp++; if (mif.hit_q !== 1'b0) begin n_err++; $display("FAIL first_edge_after_reset hit got=%b exp=0", mif.hit_q); end
    apply(1'b0, '0, 1'b0, 0, 1'b1, 35'h1_0000_0040);
    n_cmp++; if (mif.hit_q !== 1'b0 || mif.empty !== 1'b1) begin n_err++; $display("FAIL old_addr_after_reset hit/empty got=%b/%b exp=0/1", mif.hit_q, mif.empty); end
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [7];
    int errs_before;
    pool[0] = 35'h0_0000_0040; pool[1] = 35'h7_FFFF_FFC0; pool[2] = 35'h1_2345_6780;
    pool[3] = 35'h0_0000_0000; pool[4] = 35'h4_0000_0040; pool[5] = 35'h2_AAAA_5540;
    pool[6] = 35'h3_0303_0300;
    errs_before = n_err;
    for (int c = 0; c < 400; c++) begin
      apply(1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)],
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, NENT - 1)),
            1'($urandom_range(0, 1)), pool[$urandom_range(0, 6)]);
      n_cmp++; if (o_ok !== e_ok) begin n_err++; $display("FAIL rnd_alloc_ok c=%0d got=%b exp=%b", c, o_ok, e_ok); end
      if (e_ok) begin
        n_cmp++; if (o_idx !== IW'(e_idx)) begin n_err++; $display("FAIL rnd_alloc_idx c=%0d got=%0d exp=%0d", c, o_idx, e_idx); end
      end
      n_cmp++; if (mif.hit_q !== e_hit || mif.hit_vec_q !== e_vec || mif.hit_idx_q !== IW'(e_hidx)) begin n_err++; $display("FAIL rnd_hit c=%0d got=%b/%b/%0d exp=%b/%b/%0d", c, mif.hit_q, mif.hit_vec_q, mif.hit_idx_q, e_hit, e_vec, e_hidx); end
      n_cmp++; if (mif.rej_q !== e_rej) begin n_err++; $display("FAIL rnd_rej c=%0d got=%b exp=%b", c, mif.rej_q, e_rej); end
      n_cmp++; if (mif.vld_vec !== model_vec() || mif.full !== (&model_vec()) || mif.empty !== ~(|model_vec())) begin n_err++; $display("FAIL rnd_state c=%0d got=%b/%b/%b exp=%b", c, mif.vld_vec, mif.full, mif.empty, model_vec()); end
      if (n_err - errs_before > 20) break;
    end
  endtask

  initial begin
    test_reset();
    test_alloc_lookup();
    test_dup();
    test_full();
    test_free_alloc_same();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
